// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 8x8 shift-and-add multiplier.
// Holds the FSM state encoding and the operand, product and iteration sizes.
package mult_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int ITER   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/seq_mult_8_bit_if.sv
// Request/result bundle between the multiplier and its requester.
// master: drives start, a, b and reads busy, done, p. slave: the multiplier side.
interface seq_mult_8_bit_if;
    import mult_pkg::*;

    logic              start;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              busy;
    logic              done;
    logic [PROD_W-1:0] p;

    modport master (
        output start, a, b,
        input  busy, done, p
    );

    modport slave (
        input  start, a, b,
        output busy, done, p
    );

endinterface

// File: rtl/full_adder_8_bit.sv
// 8-bit ripple-carry adder used as the multiplier add step.
// Ports: a, b (8-bit addends), cin (carry in), s (8-bit sum), cout (carry out).
module full_adder_8_bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    logic [8:0] c;

    assign c[0] = cin;

    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_bit
            assign s[i]   = a[i] ^ b[i] ^ c[i];
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = c[8];

endmodule

// File: rtl/seq_mult_8_bit.sv
// Sequential unsigned 8x8 shift-and-add multiplier, one multiplier bit per clock.
// Ports: clk, rst_n (async active-low), bus.slave (start, a, b in; busy, done, p out).
module seq_mult_8_bit
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    seq_mult_8_bit_if.slave   bus
);

    mult_state_t       state;
    mult_state_t       state_nx;
    logic [OP_W-1:0]   m_q;
    logic [OP_W-1:0]   q_q;
    logic [OP_W-1:0]   a_q;
    logic              c_q;
    logic [2:0]        cnt;
    logic [PROD_W-1:0] p_q;

    logic [OP_W-1:0]   sum;
    logic              cout;
    logic [OP_W:0]     acc;
    logic              last;

    full_adder_8_bit u_add (
        .a    (a_q),
        .b    (m_q),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout)
    );

    // Add-or-pass result {C,A} before the right shift of {C,A,Q}.
    assign acc  = q_q[0] ? {cout, sum} : {1'b0, a_q};
    assign last = (cnt == 3'(ITER - 1));

    always_comb begin
        state_nx = IDLE;
        unique case (state)
            IDLE:    state_nx = bus.start ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            m_q   <= '0;
            q_q   <= '0;
            a_q   <= '0;
            c_q   <= 1'b0;
            cnt   <= '0;
            p_q   <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        m_q <= bus.a;
                        q_q <= bus.b;
                        a_q <= '0;
                        c_q <= 1'b0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    // Add and shift folded into one update; C always shifts out as 0.
                    c_q <= 1'b0;
                    a_q <= acc[OP_W:1];
                    q_q <= {acc[0], q_q[OP_W-1:1]};
                    cnt <= cnt + 3'd1;
                    if (last) begin
                        p_q <= {acc[OP_W:1], acc[0], q_q[OP_W-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.p    = p_q;

endmodule
